// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: one shared up-counter, per-channel compare logic,
// and shadow/active double-buffering so that new configuration only takes effect at a period boundary.
module pwm_gen_mc #(
  parameter int NCH = 4,
  parameter int W   = 16,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pwm_en,
  input  logic [NCH-1:0] ch_en,
  input  logic [W-1:0]   period_in,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_cmp1,
  input  logic [W-1:0]   cfg_cmp2,
  input  logic [2:0]     cfg_func,
  output logic [W-1:0]   count_val,
  output logic           period_end,
  output logic [NCH-1:0] pwm_out
);

  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   actPeriod_q;
  logic           periodEnd_q, periodEnd_d;
  logic [NCH-1:0] pwm_q, pwm_d;

  logic [W-1:0] shCmp1_q  [NCH];
  logic [W-1:0] shCmp2_q  [NCH];
  logic [2:0]   shFunc_q  [NCH];
  logic [W-1:0] actCmp1_q [NCH];
  logic [W-1:0] actCmp2_q [NCH];
  logic [2:0]   actFunc_q [NCH];

  logic           wrap;
  logic           update;
  logic [31:0]    cfgChExt;
  logic [NCH-1:0] rawLvl;

  // Disabling the generator also acts as a reload point, so software can stage a fresh setup while idle.
  assign wrap     = pwm_en && (cnt_q == actPeriod_q);
  assign update   = wrap || !pwm_en;
  assign cfgChExt = 32'(cfg_ch);

  always_comb begin
    cnt_d       = '0;
    periodEnd_d = wrap;
    if (pwm_en && !wrap) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    rawLvl = '0;
    pwm_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (actCmp1_q[i] != actCmp2_q[i]) begin
        if (actFunc_q[i][1]) begin
          rawLvl[i] = (cnt_q >= actCmp1_q[i]) && (cnt_q < actCmp2_q[i]);
        end else if (actFunc_q[i][0]) begin
          rawLvl[i] = (cnt_q >= actCmp1_q[i]);
        end else begin
          rawLvl[i] = (actCmp1_q[i] != '0) && (cnt_q <= actCmp1_q[i]);
        end
      end
      pwm_d[i] = pwm_en && ch_en[i] && (rawLvl[i] ^ actFunc_q[i][2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      periodEnd_q <= 1'b0;
      pwm_q       <= '0;
      actPeriod_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      periodEnd_q <= periodEnd_d;
      pwm_q       <= pwm_d;
      if (update) begin
        actPeriod_q <= period_in;
      end
    end
  end

  // Active registers take the pre-edge shadow, so a write landing on a wrap edge waits one more period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        shCmp1_q[i]  <= '0;
        shCmp2_q[i]  <= '0;
        shFunc_q[i]  <= '0;
        actCmp1_q[i] <= '0;
        actCmp2_q[i] <= '0;
        actFunc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (update) begin
          actCmp1_q[i] <= shCmp1_q[i];
          actCmp2_q[i] <= shCmp2_q[i];
          actFunc_q[i] <= shFunc_q[i];
        end
        if (cfg_we && (cfgChExt == 32'(i))) begin
          shCmp1_q[i] <= cfg_cmp1;
          shCmp2_q[i] <= cfg_cmp2;
          shFunc_q[i] <= cfg_func;
        end
      end
    end
  end

  assign count_val  = cnt_q;
  assign period_end = periodEnd_q;
  assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Directed bench for pwm_gen_mc with a cycle-level reference model feeding a scoreboard queue.
module tb_pwm_gen_mc;

  localparam int NCH = 3;
  localparam int W   = 16;

  logic           clk;
  logic           rst_n;
  logic           pwm_en;
  logic [NCH-1:0] ch_en;
  logic [W-1:0]   period_in;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_cmp1;
  logic [W-1:0]   cfg_cmp2;
  logic [2:0]     cfg_func;
  logic [W-1:0]   count_val;
  logic           period_end;
  logic [NCH-1:0] pwm_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]   cnt;
    logic           pe;
    logic [NCH-1:0] pwm;
  } expT;

  expT sbQ[$];

  logic [W-1:0]   mCnt, mPer;
  logic           mPe;
  logic [NCH-1:0] mPwm;
  logic [W-1:0]   mS1 [NCH];
  logic [W-1:0]   mS2 [NCH];
  logic [2:0]     mSf [NCH];
  logic [W-1:0]   mA1 [NCH];
  logic [W-1:0]   mA2 [NCH];
  logic [2:0]     mAf [NCH];

  pwm_gen_mc #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_en    (pwm_en),
    .ch_en     (ch_en),
    .period_in (period_in),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_cmp1  (cfg_cmp1),
    .cfg_cmp2  (cfg_cmp2),
    .cfg_func  (cfg_func),
    .count_val (count_val),
    .period_end(period_end),
    .pwm_out   (pwm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCnt = '0; mPer = '0; mPe = 1'b0; mPwm = '0;
    for (int i = 0; i < NCH; i++) begin
      mS1[i] = '0; mS2[i] = '0; mSf[i] = '0;
      mA1[i] = '0; mA2[i] = '0; mAf[i] = '0;
    end
  endtask

  // Reference model of one clock edge, evaluated on the inputs currently driven.
  task automatic modelStep();
    logic           raw;
    logic           wrapM;
    logic [NCH-1:0] nPwm;
    logic [W-1:0]   nCnt;
    expT            e;
    wrapM = pwm_en && (mCnt == mPer);
    for (int i = 0; i < NCH; i++) begin
      raw = 1'b0;
      if (mA1[i] != mA2[i]) begin
        case (mAf[i][1:0])
          2'b00:   raw = (mA1[i] != 0) && (mCnt <= mA1[i]);
          2'b01:   raw = (mCnt >= mA1[i]);
          default: raw = (mCnt >= mA1[i]) && (mCnt < mA2[i]);
        endcase
      end
      nPwm[i] = (pwm_en && ch_en[i]) ? (raw ^ mAf[i][2]) : 1'b0;
    end
    nCnt = (!pwm_en || wrapM) ? '0 : mCnt + 1;
    if (wrapM || !pwm_en) begin
      mPer = period_in;
      for (int i = 0; i < NCH; i++) begin
        mA1[i] = mS1[i]; mA2[i] = mS2[i]; mAf[i] = mSf[i];
      end
    end
    if (cfg_we && (int'(cfg_ch) < NCH)) begin
      mS1[cfg_ch] = cfg_cmp1; mS2[cfg_ch] = cfg_cmp2; mSf[cfg_ch] = cfg_func;
    end
    mCnt = nCnt; mPe = wrapM; mPwm = nPwm;
    e.cnt = mCnt; e.pe = mPe; e.pwm = mPwm;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checkVal("scoreboard_empty", 32'(sbQ.size()), 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkVal("count_val", 32'(count_val), 32'(e.cnt));
      checkVal("period_end", 32'(period_end), 32'(e.pe));
      checkVal("pwm_out", 32'(pwm_out), 32'(e.pwm));
    end
  endtask

  task automatic runCycle();
    applyStimulus();
    checkOutput();
  endtask

  task automatic runN(input int n);
    for (int k = 0; k < n; k++) runCycle();
  endtask

  task automatic writeCfg(input logic [1:0] ch, input logic [W-1:0] c1,
                          input logic [W-1:0] c2, input logic [2:0] f);
    cfg_we = 1'b1; cfg_ch = ch; cfg_cmp1 = c1; cfg_cmp2 = c2; cfg_func = f;
    runCycle();
    cfg_we = 1'b0;
  endtask

  // Advances until the DUT counter shows the requested value, with a bounded budget.
  task automatic waitCount(input logic [W-1:0] target);
    for (int k = 0; k < 40 && count_val != target; k++) runCycle();
    checkVal("reach_count", 32'(count_val), 32'(target));
  endtask

  initial begin
    rst_n = 1'b1; pwm_en = 1'b0; ch_en = '0; period_in = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_cmp1 = '0; cfg_cmp2 = '0; cfg_func = '0;
    modelReset();
    #2 rst_n = 1'b0;
    #1;
    checkVal("reset_count", 32'(count_val), 32'd0);
    checkVal("reset_pe", 32'(period_end), 32'd0);
    checkVal("reset_pwm", 32'(pwm_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] configure channels while disabled");
    period_in = 16'd9;
    ch_en     = 3'b111;
    writeCfg(2'd0, 16'd3, 16'd0, 3'd0);
    writeCfg(2'd1, 16'd2, 16'd6, 3'd2);
    writeCfg(2'd2, 16'd7, 16'd0, 3'd1);
    writeCfg(2'd3, 16'd1, 16'd9, 3'd4);
    runN(2);

    $display("[TB] run with left/unaligned/right channels");
    pwm_en = 1'b1;
    runN(14);
    waitCount(16'd4);
    writeCfg(2'd1, 16'd2, 16'd8, 3'd2);
    runN(3);
    waitCount(16'd9);
    writeCfg(2'd1, 16'd2, 16'd4, 3'd2);
    runN(22);
    waitCount(16'd9);
    writeCfg(2'd2, 16'd7, 16'd0, 3'd5);
    runN(22);
    ch_en = 3'b011;
    runN(12);

    $display("[TB] equal compares and left-align zero");
    ch_en = 3'b111;
    writeCfg(2'd0, 16'd5, 16'd5, 3'd1);
    writeCfg(2'd1, 16'd5, 16'd5, 3'd2);
    writeCfg(2'd2, 16'd0, 16'd3, 3'd4);
    runN(25);

    $display("[TB] zero period");
    period_in = 16'd0;
    runN(15);
    checkVal("per0_count", 32'(count_val), 32'd0);
    checkVal("per0_pe", 32'(period_end), 32'd1);
    pwm_en = 1'b0;
    runN(3);

    $display("[TB] asynchronous reset mid-period");
    period_in = 16'd9;
    pwm_en    = 1'b1;
    runN(3);
    writeCfg(2'd0, 16'd1, 16'd6, 3'd2);
    waitCount(16'd5);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("async_count", 32'(count_val), 32'd0);
    checkVal("async_pe", 32'(period_end), 32'd0);
    checkVal("async_pwm", 32'(pwm_out), 32'd0);
    @(posedge clk);
    #1;
    checkVal("hold_count", 32'(count_val), 32'd0);
    rst_n = 1'b1;
    runN(24);
    checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen_mc.md
PWM_GEN_MC -- requirements
Module: pwm_gen_mc

Interface
REQ-001 The block SHALL take parameter NCH, default 4, as the number of independent PWM channels (1..16).
REQ-002 The block SHALL take parameter W, default 16, as the width of the counter, period and compare values (4..32).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port pwm_en, input, 1, global enable for the counter and all outputs.
REQ-006 The block SHALL have port ch_en, input, NCH, per-channel output enable.
REQ-007 The block SHALL have port period_in, input, W, requested period (counter terminal value).
REQ-008 The block SHALL have port cfg_we, input, 1, single-cycle write strobe for channel shadow configuration.
REQ-009 The block SHALL have port cfg_ch, input, max(1,clog2(NCH)), target channel index for cfg_we.
REQ-010 The block SHALL have ports cfg_cmp1 and cfg_cmp2, input, W each, requested compare values.
REQ-011 The block SHALL have port cfg_func, input, 3, requested mode: bit0 right-align, bit1 unaligned, bit2 invert polarity.
REQ-012 The block SHALL have port count_val, output, W, current shared counter value.
REQ-013 The block SHALL have port period_end, output, 1, registered one-cycle pulse marking a counter wrap.
REQ-014 The block SHALL have port pwm_out, output, NCH, registered PWM outputs, bit i = channel i.

Function
REQ-015 Counter: with pwm_en=1, count_val increments by 1 per cycle; at count_val==active period, next value is 0 (wrap).
REQ-016 Active period 0: count_val stays 0 and wraps every cycle.
REQ-017 pwm_en=0: count_val forced to 0 at the next edge; period_end and all pwm_out bits 0 at the next edge.
REQ-018 period_end SHALL be 1 exactly in the cycle following a wrap edge (coincident with count_val==0 after wrap); constant 1 while period 0 and enabled.
REQ-019 Shadow write: cfg_we=1 with cfg_ch<NCH loads cfg_cmp1, cfg_cmp2, cfg_func into that channel's shadow; cfg_ch>=NCH ignored.
REQ-020 Update: active period and all active channel registers load their shadow values (period shadow = period_in) on every wrap edge and on every edge with pwm_en=0.
REQ-021 A shadow write on the same edge as a wrap SHALL not reach active until the following wrap; active takes the pre-edge shadow.
REQ-022 Raw level per channel, from active values and current count_val c: cmp1==cmp2 -> 0; else left-align (bit1=0,bit0=0): cmp1==0 -> 0, else c<=cmp1; right-align (bit1=0,bit0=1): c>=cmp1; unaligned (bit1=1): cmp1<=c<cmp2.
REQ-023 pwm_out[i] at cycle t+1 SHALL equal raw level at cycle t XOR bit2, when pwm_en=1 and ch_en[i]=1 at t; otherwise 0 (polarity never applied to disabled channel).
REQ-024 Latency: one cycle from count_val/ch_en to pwm_out; one period boundary from shadow write to effect.
REQ-025 All comparisons unsigned, W bits; no arithmetic overflow possible since counter never exceeds active period.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear count_val, period_end, pwm_out, all shadow and active registers to 0.
REQ-027 Reset mid-period SHALL discard pending shadow writes; after release, counting restarts from 0 on first enabled edge.

Verification
REQ-028 W=16, period_in=9, ch0 func=0 cmp1=3 cmp2=0, pwm_en=1 -> pwm_out[0]=1 for c=0..3, 0 for 4..9, period 10 cycles, 1-cycle lag.
REQ-029 ch1 func=2 cmp1=2 cmp2=6 -> high for c=2..5; change cmp2 to 8 at c=4 -> effect only after next wrap; write at wrap edge -> effect one period later.
REQ-030 ch2 func=1 cmp1=7 period 9, then func=5 -> high c=7..9, then inverted (high c=0..6); ch_en[2]=0 -> output 0.
REQ-031 cmp1==cmp2=5 any mode -> 0; left-align cmp1=0 -> 0; period_in=0 -> count_val 0, period_end constant 1.
REQ-032 Assert rst_n=0 at c=5 with pending shadow write -> all outputs 0 immediately; after release, old shadow gone, active=0.
